// File: rtl/if_stage_pkg.sv
// Shared constants, FSM state encodings and payload type for the instruction fetch stage.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    TRAP  = 2'd3
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fetch_pkt_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry hold buffer parking a fetch response that arrived while IF/ID was stalled.
module if_skid_buffer
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instruction,
  output logic            full,
  output logic [XLEN-1:0] held_pc,
  output logic [XLEN-1:0] held_instruction
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      full             <= 1'b0;
      held_pc          <= '0;
      held_instruction <= NOP_INSTR;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full             <= 1'b1;
      held_pc          <= pc;
      held_instruction <= instruction;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request, IF/ID register and a hold buffer.
// Optional IF_MISALIGN_TRAP_EN turns misaligned redirects into a TRAP presentation.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instruction,
  output logic            if_id_valid,
  output logic            if_id_misaligned
);

  if_state_e       state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            hold_full;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] hold_instruction;
  fetch_pkt_t      rsp_pkt;
  fetch_pkt_t      hold_pkt;
  logic            req_fire;
  logic            rsp_take;
  logic            advance;
  logic            hold_load;
  logic            hold_unload;
  logic            hold_clear;
  logic            present_hold;
  logic            present_rsp;
  logic            present_trap;
  logic            redirect_misaligned;
  logic [XLEN-1:0] redirect_target;

  assign imem_req_valid = reset && (state == FETCH) && !stall && !hold_full;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = (state == WAIT) && imem_rsp_valid;
  assign advance        = !redirect_valid && !flush && !stall;

  assign rsp_pkt  = '{pc: req_pc, instruction: imem_rsp_data};
  assign hold_pkt = '{pc: hold_pc, instruction: hold_instruction};

  assign hold_clear   = redirect_valid || flush;
  assign hold_load    = rsp_take && stall && !redirect_valid && !flush;
  assign hold_unload  = advance && hold_full;
  assign present_hold = advance && hold_full;
  assign present_rsp  = advance && !hold_full && rsp_take;

`ifdef IF_MISALIGN_TRAP_EN
  logic trap_pending;

  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign redirect_target     = redirect_pc;
  assign present_trap        = advance && trap_pending;

  // Trap payload is presented exactly once per misaligned redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      trap_pending <= 1'b0;
    end else if (redirect_valid) begin
      trap_pending <= redirect_misaligned;
    end else if (present_trap) begin
      trap_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if_id_misaligned <= 1'b0;
    end else if (present_trap) begin
      if_id_misaligned <= 1'b1;
    end else if (redirect_valid || flush || !stall) begin
      if_id_misaligned <= 1'b0;
    end
  end
`else
  assign redirect_misaligned = 1'b0;
  assign redirect_target     = redirect_pc & PC_ALIGN_MASK;
  assign present_trap        = 1'b0;
  assign if_id_misaligned    = 1'b0;
`endif

  if_skid_buffer u_hold (
    .clk              (clk),
    .reset            (reset),
    .load             (hold_load),
    .unload           (hold_unload),
    .clear            (hold_clear),
    .pc               (rsp_pkt.pc),
    .instruction      (rsp_pkt.instruction),
    .full             (hold_full),
    .held_pc          (hold_pc),
    .held_instruction (hold_instruction)
  );

  // Fetch FSM and PC; a reset during an outstanding request drains its response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      if ((state == WAIT || state == DRAIN) && !imem_rsp_valid) begin
        state <= DRAIN;
      end else begin
        state <= FETCH;
      end
    end else if (redirect_valid) begin
      pc <= redirect_target;
      if (redirect_misaligned) begin
        state <= TRAP;
      end else begin
        case (state)
          FETCH:       state <= req_fire ? DRAIN : FETCH;
          WAIT, DRAIN: state <= imem_rsp_valid ? FETCH : DRAIN;
          default:     state <= FETCH;
        endcase
      end
    end else begin
      case (state)
        FETCH: begin
          if (req_fire) begin
            state  <= WAIT;
            req_pc <= pc;
            pc     <= pc + PC_STEP;
          end
        end
        WAIT, DRAIN: begin
          if (imem_rsp_valid) begin
            state <= FETCH;
          end
        end
        default: state <= TRAP;
      endcase
    end
  end

  // IF/ID register: redirect/flush kill, stall holds, otherwise present or go empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_id_valid       <= 1'b0;
      if_id_pc          <= '0;
      if_id_instruction <= NOP_INSTR;
    end else if (redirect_valid || flush) begin
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if (present_hold) begin
        {if_id_pc, if_id_instruction} <= hold_pkt;
        if_id_valid                   <= 1'b1;
      end else if (present_rsp) begin
        {if_id_pc, if_id_instruction} <= rsp_pkt;
        if_id_valid                   <= 1'b1;
      end else if (present_trap) begin
        if_id_pc          <= pc;
        if_id_instruction <= NOP_INSTR;
        if_id_valid       <= 1'b1;
      end else begin
        if_id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: transaction-level reference model of the fetch/IF-ID contract
// driving a one-outstanding memory; define IF_MISALIGN_TRAP_EN to exercise the trap path.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IF_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic [31:0] if_id_pc, if_id_instruction;
  logic        if_id_valid, if_id_misaligned;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem_req_valid    (imem_req_valid),
    .imem_req_addr     (imem_req_addr),
    .imem_req_ready    (imem_req_ready),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid),
    .if_id_misaligned  (if_id_misaligned)
  );

  int checks = 0;
  int errors = 0;

  // memory side
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_delay = 0;
  int          lat = 0;

  // reference model state
  logic [31:0] m_pc = RST_PC;
  logic        m_out = 1'b0, m_live = 1'b0;
  logic [31:0] m_out_addr = '0;
  logic        m_pend = 1'b0;
  logic [31:0] m_pend_addr = '0;
  logic        m_v = 1'b0, m_vmis = 1'b0;
  logic [31:0] m_vpc = '0, m_vinstr = '0;
  logic        m_trap = 1'b0, m_tpend = 1'b0;

  logic        rst_low = 1'b1;
  logic        seen_req = 1'b0;
  logic [31:0] seen_addr = '0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h0010_0093;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] i, input logic mis);
    m_v = 1'b1; m_vpc = a; m_vinstr = i; m_vmis = mis;
  endtask

  // One clock: drive at negedge, check request, update memory + model after the edge.
  task automatic step(input logic s, input logic f, input logic r,
                      input logic [31:0] rpc, input logic rdy);
    logic        rv, acc, arr, trap_tgt;
    logic [31:0] arr_addr, tgt;
    reset = !rst_low; stall = s; flush = f; redirect_valid = r;
    redirect_pc = rpc; imem_req_ready = rdy;
    rv = mem_busy && (mem_delay == 0);
    imem_rsp_valid = rv;
    imem_rsp_data = rv ? word(mem_addr) : $urandom();
    #1;
    seen_req = imem_req_valid;
    seen_addr = imem_req_addr;
    check("req_valid", 32'(imem_req_valid), 32'(!rst_low && !s && !m_pend && !m_out && !m_trap));
    if (imem_req_valid) check("req_addr", imem_req_addr, m_pc);
    acc = imem_req_valid && rdy;
    @(posedge clk);
    #1;
    if (rv) mem_busy = 1'b0;
    else if (mem_busy) mem_delay--;
    if (acc) begin
      mem_busy = 1'b1; mem_addr = seen_addr; mem_delay = lat;
    end
    arr = 1'b0; arr_addr = '0;
    if (rv) begin
      m_out = 1'b0; arr = m_live; arr_addr = m_out_addr;
    end
    tgt = TRAP_EN ? rpc : (rpc & 32'hFFFF_FFFC);
    trap_tgt = TRAP_EN && (rpc[1:0] != 2'b00);
    if (rst_low) begin
      m_pc = RST_PC; m_v = 1'b0; m_vmis = 1'b0; m_pend = 1'b0; m_trap = 1'b0; m_tpend = 1'b0;
      if (m_out) m_live = 1'b0;
    end else if (r) begin
      m_v = 1'b0; m_vmis = 1'b0; m_pend = 1'b0; m_pc = tgt; m_trap = trap_tgt; m_tpend = trap_tgt;
      if (acc) begin
        m_out = 1'b1; m_live = 1'b0;
      end else if (m_out) begin
        m_live = 1'b0;
      end
    end else begin
      if (acc) begin
        m_out = 1'b1; m_live = 1'b1; m_out_addr = m_pc; m_pc = m_pc + 32'd4;
      end
      if (f) begin
        m_v = 1'b0; m_vmis = 1'b0; m_pend = 1'b0;
      end else if (s) begin
        if (arr) begin
          m_pend = 1'b1; m_pend_addr = arr_addr;
        end
      end else if (m_pend) begin
        present(m_pend_addr, word(m_pend_addr), 1'b0);
        m_pend = 1'b0;
      end else if (arr) begin
        present(arr_addr, word(arr_addr), 1'b0);
      end else if (m_tpend) begin
        present(m_pc, NOP, 1'b1);
        m_tpend = 1'b0;
      end else begin
        m_v = 1'b0; m_vmis = 1'b0;
      end
    end
    check("if_id_valid", 32'(if_id_valid), 32'(m_v));
    if (m_v) begin
      check("if_id_pc", if_id_pc, m_vpc);
      check("if_id_instruction", if_id_instruction, m_vinstr);
    end
    check("if_id_misaligned", 32'(if_id_misaligned), 32'(m_v && m_vmis));
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_pc", if_id_pc, 32'd0);
    check("rst_instr", if_id_instruction, NOP);
    check("rst_mis", 32'(if_id_misaligned), 32'd0);
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);

    // first fetch after reset release
    rst_low = 1'b0; lat = 0;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("first_req_valid", 32'(seen_req), 32'd1);
    check("first_req_addr", seen_addr, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("first_valid", 32'(if_id_valid), 32'd1);
    check("first_pc", if_id_pc, 32'h0);
    check("first_instr", if_id_instruction, 32'h0010_0093);

    // response during stall parks in the hold buffer
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("stall_hold_valid", 32'(if_id_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("stall_no_req_full", 32'(seen_req), 32'd0);
    check("stall_release_valid", 32'(if_id_valid), 32'd1);
    check("stall_release_pc", if_id_pc, 32'h4);
    check("stall_release_instr", if_id_instruction, word(32'h4));

    // redirect while waiting drops the late response
    lat = 1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    lat = 0;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("drain_drop_valid", 32'(if_id_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("redir_req_addr", seen_addr, 32'h100);
    check("redir_req_valid", 32'(seen_req), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // PC wrap
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_req_top", seen_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_req_zero", seen_addr, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap_rsp_pc", if_id_pc, 32'h0);

    // flush beats stall, PC untouched
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("flush_stall_valid", 32'(if_id_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("flush_pc_kept", seen_addr, 32'h4);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

`ifdef IF_MISALIGN_TRAP_EN
    step(1'b0, 1'b0, 1'b1, 32'h102, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("trap_valid", 32'(if_id_valid), 32'd1);
    check("trap_mis", 32'(if_id_misaligned), 32'd1);
    check("trap_pc", if_id_pc, 32'h102);
    check("trap_instr", if_id_instruction, NOP);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("trap_no_req", 32'(seen_req), 32'd0);
    end
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("trap_exit_req", seen_addr, 32'h200);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
`else
    step(1'b0, 1'b0, 1'b1, 32'h102, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("align_req_addr", seen_addr, 32'h100);
    check("align_mis", 32'(if_id_misaligned), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
`endif

    // reset while waiting: the stale response is ignored
    lat = 2;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    rst_low = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    rst_low = 1'b0;
    lat = 0;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_wait_drop", 32'(if_id_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_wait_req", seen_addr, RST_PC);
    check("rst_wait_req_valid", 32'(seen_req), 32'd1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rpc;
      lat = int'($urandom_range(0, 2));
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                         : ($urandom() & 32'h0000_FFFF);
      if (TRAP_EN) rpc[1:0] = 2'b00;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 11) == 0, rpc, $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
